// File: rtl/led_show_sequencer.sv
// Timed show sequencer: plays program entries onto the LED controller bus,
// with optional per-step brightness fade-in, single-shot or looping.
module led_show_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PRESCALE = 1000,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [17:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [1:0]    mode,
  output logic [3:0]    color_code,
  output logic [3:0]    brightness,
  output logic [AW-1:0] step,
  output logic          busy,
  output logic          done
);

  localparam int unsigned PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {StIdle, StLoad, StFade, StHold} state_e;

  state_e          state_q, state_d;
  logic [17:0]     mem_q [DEPTH];
  logic [1:0]      mode_q, mode_d;
  logic [3:0]      color_q, color_d;
  logic [3:0]      bri_q, bri_d;
  logic [3:0]      target_q, target_d;
  logic [5:0]      hold_q, hold_d;
  logic            last_q, last_d;
  logic [AW-1:0]   step_q, step_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0]      tcnt_q, tcnt_d;
  logic            done_q, done_d;
  logic [17:0]     entry;
  logic            tick;
  logic            step_last;

  assign entry     = mem_q[step_q];
  assign tick      = (presc_q == PW'(PRESCALE - 1));
  assign step_last = last_q || (step_q == AW'(DEPTH - 1));

  // Program memory survives reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    color_d  = color_q;
    bri_d    = bri_q;
    target_d = target_q;
    hold_d   = hold_q;
    last_d   = last_q;
    step_d   = step_q;
    presc_d  = presc_q;
    tcnt_d   = tcnt_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (start) begin
          state_d = StLoad;
          step_d  = '0;
        end
      end
      StLoad: begin
        mode_d   = entry[15:14];
        color_d  = entry[13:10];
        target_d = entry[9:6];
        hold_d   = entry[5:0];
        last_d   = entry[17];
        presc_d  = '0;
        tcnt_d   = '0;
        if (entry[16] && (entry[9:6] != 4'd0)) begin
          bri_d   = 4'd0;
          state_d = StFade;
        end else begin
          bri_d   = entry[9:6];
          state_d = StHold;
        end
      end
      StFade: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          bri_d = bri_q + 4'd1;
          if ((bri_q + 4'd1) == target_q) begin
            state_d = StHold;
            tcnt_d  = '0;
          end
        end
      end
      StHold: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (tcnt_q == hold_q) begin
            if (!step_last) begin
              step_d  = step_q + AW'(1);
              state_d = StLoad;
            end else if (loop) begin
              step_d  = '0;
              state_d = StLoad;
            end else begin
              state_d = StIdle;
              mode_d  = '0;
              color_d = '0;
              bri_d   = '0;
              step_d  = '0;
              presc_d = '0;
              tcnt_d  = '0;
              done_d  = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a same-cycle start.
    if (stop) begin
      state_d = StIdle;
      mode_d  = '0;
      color_d = '0;
      bri_d   = '0;
      step_d  = '0;
      presc_d = '0;
      tcnt_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      color_q  <= '0;
      bri_q    <= '0;
      target_q <= '0;
      hold_q   <= '0;
      last_q   <= 1'b0;
      step_q   <= '0;
      presc_q  <= '0;
      tcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      color_q  <= color_d;
      bri_q    <= bri_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
      tcnt_q   <= tcnt_d;
      done_q   <= done_d;
    end
  end

  assign mode       = mode_q;
  assign color_code = color_q;
  assign brightness = bri_q;
  assign step       = step_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_led_show_sequencer.sv
// Directed bench: each step queues the cycle-by-cycle bus values it should
// produce, then those are popped and compared one clock at a time.
module tb_led_show_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [17:0]   wr_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic [1:0]    mode;
  logic [3:0]    color_code;
  logic [3:0]    brightness;
  logic [AW-1:0] step;
  logic          busy;
  logic          done;

  led_show_sequencer #(
    .DEPTH    (DEPTH),
    .PRESCALE (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .mode       (mode),
    .color_code (color_code),
    .brightness (brightness),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  localparam logic [14:0] IDLE_V = 15'd0;

  // {mode, color, brightness, step, busy, done}
  function automatic logic [14:0] pk(input logic [1:0] m, input logic [3:0] c,
                                     input logic [3:0] b, input logic [2:0] s,
                                     input logic bz, input logic d);
    return {m, c, b, s, bz, d};
  endfunction

  function automatic logic [17:0] ent(input logic l, input logic f, input logic [1:0] m,
                                      input logic [3:0] c, input logic [3:0] b,
                                      input logic [5:0] h);
    return {l, f, m, c, b, h};
  endfunction

  task automatic push(input logic [14:0] v, input int n, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t        e;
    logic [14:0] obs;
    repeat (n) begin
      @(posedge clk);
      #1;
      obs = {mode, color_code, brightness, step, busy, done};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL underflow: got %h required nothing queued", obs);
      end else begin
        e = exp_q.pop_front();
        assert (obs === e.v) passes++;
        else $error("FAIL %s: got %h required %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [17:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    push(IDLE_V, 1, "write_idle");
    run(1);
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;

    // Reset and quiet idle
    push(IDLE_V, 2, "reset");
    run(2);
    rst = 1'b0;
    push(IDLE_V, 20, "idle");
    run(20);

    // Two-step single shot
    wr(3'd0, ent(1'b0, 1'b0, 2'd1, 4'd5, 4'd15, 6'd1));
    wr(3'd1, ent(1'b1, 1'b0, 2'd2, 4'd0, 4'd9, 6'd0));
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "s1_load0");
    run(1);
    start = 1'b0;
    push(pk(2'd1, 4'd5, 4'd15, 3'd0, 1'b1, 1'b0), 8, "s1_e0");
    push(pk(2'd1, 4'd5, 4'd15, 3'd1, 1'b1, 1'b0), 1, "s1_load1");
    push(pk(2'd2, 4'd0, 4'd9, 3'd1, 1'b1, 1'b0), 4, "s1_e1");
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1), 1, "s1_done");
    push(IDLE_V, 3, "s1_after");
    run(17);

    // Fade-in single step
    wr(3'd0, ent(1'b1, 1'b1, 2'd1, 4'd3, 4'd3, 6'd0));
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "fade_load");
    run(1);
    start = 1'b0;
    for (int b = 0; b < 4; b++) push(pk(2'd1, 4'd3, 4'(b), 3'd0, 1'b1, 1'b0), 4, "fade_ramp");
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1), 1, "fade_done");
    push(IDLE_V, 2, "fade_after");
    run(19);

    // Looping, with a write attempted while busy and loop dropped in step 1
    wr(3'd0, ent(1'b0, 1'b0, 2'd1, 4'd5, 4'd15, 6'd1));
    loop  = 1'b1;
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "lp_load0");
    run(1);
    start   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = ent(1'b1, 1'b0, 2'd3, 4'd15, 4'd1, 6'd0);
    push(pk(2'd1, 4'd5, 4'd15, 3'd0, 1'b1, 1'b0), 8, "lp_e0_a");
    run(8);
    wr_en = 1'b0;
    push(pk(2'd1, 4'd5, 4'd15, 3'd1, 1'b1, 1'b0), 1, "lp_load1_a");
    push(pk(2'd2, 4'd0, 4'd9, 3'd1, 1'b1, 1'b0), 4, "lp_e1_a");
    push(pk(2'd2, 4'd0, 4'd9, 3'd0, 1'b1, 1'b0), 1, "lp_wrap");
    push(pk(2'd1, 4'd5, 4'd15, 3'd0, 1'b1, 1'b0), 8, "lp_e0_b");
    push(pk(2'd1, 4'd5, 4'd15, 3'd1, 1'b1, 1'b0), 1, "lp_load1_b");
    run(15);
    loop = 1'b0;
    push(pk(2'd2, 4'd0, 4'd9, 3'd1, 1'b1, 1'b0), 4, "lp_e1_b");
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1), 1, "lp_done");
    push(IDLE_V, 2, "lp_after");
    run(7);

    // Stop mid-hold
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "st_load");
    run(1);
    start = 1'b0;
    push(pk(2'd1, 4'd5, 4'd15, 3'd0, 1'b1, 1'b0), 3, "st_e0");
    run(3);
    stop = 1'b1;
    push(IDLE_V, 1, "st_abort");
    run(1);
    stop = 1'b0;
    push(IDLE_V, 3, "st_after");
    run(3);

    // Stop together with start, mid-playback and while idle
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "ss_load");
    run(1);
    start = 1'b0;
    push(pk(2'd1, 4'd5, 4'd15, 3'd0, 1'b1, 1'b0), 2, "ss_e0");
    run(2);
    start = 1'b1;
    stop  = 1'b1;
    push(IDLE_V, 3, "ss_abort");
    run(3);
    start = 1'b0;
    stop  = 1'b0;
    push(IDLE_V, 2, "ss_after");
    run(2);

    // Write and start together; reset mid-fade keeps the program
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = ent(1'b1, 1'b1, 2'd2, 4'd7, 4'd2, 6'd0);
    start   = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "ws_load");
    run(1);
    wr_en = 1'b0;
    start = 1'b0;
    push(pk(2'd2, 4'd7, 4'd0, 3'd0, 1'b1, 1'b0), 4, "ws_b0");
    push(pk(2'd2, 4'd7, 4'd1, 3'd0, 1'b1, 1'b0), 2, "ws_b1");
    run(6);
    rst = 1'b1;
    push(IDLE_V, 1, "rst_fade");
    run(1);
    rst = 1'b0;
    push(IDLE_V, 2, "rst_after");
    run(2);
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "rp_load");
    run(1);
    start = 1'b0;
    for (int b = 0; b < 3; b++) push(pk(2'd2, 4'd7, 4'(b), 3'd0, 1'b1, 1'b0), 4, "rp_ramp");
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1), 1, "rp_done");
    push(IDLE_V, 2, "rp_after");
    run(15);

    // Full table without last bits: entry DEPTH-1 ends playback
    for (int i = 0; i < 8; i++) wr(3'(i), ent(1'b0, 1'b0, 2'd1, 4'(i), 4'(i), 6'd0));
    start = 1'b1;
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0), 1, "full_load0");
    run(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(pk(2'd1, 4'(i), 4'(i), 3'(i), 1'b1, 1'b0), 4, "full_step");
      if (i < 7) push(pk(2'd1, 4'(i), 4'(i), 3'(i + 1), 1'b1, 1'b0), 1, "full_load");
    end
    push(pk(2'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1), 1, "full_done");
    push(IDLE_V, 2, "full_after");
    run(42);

    checks++;
    assert (exp_q.size() == 0) passes++;
    else $error("FAIL leftover: got %0d queued required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
